// File: rtl/ram_sched_pkg.sv
// Shared types and default constants for the ram32x4 access scheduler.
package ram_sched_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } sched_state_t;

  localparam int DEF_AW = 5;
  localparam int DEF_DW = 4;
  localparam logic [3:0] DEF_CLEAR_VAL = 4'h0;

endpackage

// File: rtl/ram_access_sched_scan_seq.sv
// Tick-paced read scanner: pointer, read-latency valid pipeline and capture.
// RAM_ACCESS_SCHED_RAW_BYPASS_EN adds write-to-in-flight-read forwarding.
module scan_seq
  import ram_sched_pkg::*;
#(
  parameter int AW         = DEF_AW,
  parameter int DW         = DEF_DW,
  parameter int RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          scan_en,
`ifdef RAM_ACCESS_SCHED_RAW_BYPASS_EN
  input  logic          wr_en,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
`endif
  input  logic [DW-1:0] ram_q,
  output logic [AW-1:0] ram_rdaddress,
  output logic [AW-1:0] scan_addr,
  output logic [DW-1:0] scan_data,
  output logic          scan_valid
);

  localparam int NST = RD_LATENCY + 1;

  logic          step;
  logic [AW-1:0] ptr_q;
  logic [NST-1:0] vld_q;
  logic [AW-1:0] addr_q [NST];
  logic [DW-1:0] cap_data;

  assign step          = tick & scan_en;
  assign ram_rdaddress = ptr_q;

  // Stage i holds a read i cycles after its address was presented to the RAM;
  // the last stage lines up with ram_q being valid.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_q <= '0;
      vld_q <= '0;
      for (int i = 0; i < NST; i++) addr_q[i] <= '0;
    end else begin
      if (step) ptr_q <= ptr_q + 1'b1;
      vld_q[0]  <= step;
      addr_q[0] <= ptr_q + 1'b1;
      for (int i = 1; i < NST; i++) begin
        vld_q[i]  <= vld_q[i-1];
        addr_q[i] <= addr_q[i-1];
      end
    end
  end

`ifdef RAM_ACCESS_SCHED_RAW_BYPASS_EN
  logic [NST-1:0] hit;
  logic [NST-1:0] byp_q;
  logic [DW-1:0]  bdat_q [NST];

  always_comb begin
    hit = '0;
    for (int i = 0; i < NST; i++)
      hit[i] = vld_q[i] & wr_en & (wr_addr == addr_q[i]);
  end

  // A later hit overwrites an earlier one so the newest write data wins.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      byp_q <= '0;
      for (int i = 0; i < NST; i++) bdat_q[i] <= '0;
    end else begin
      byp_q[0]  <= 1'b0;
      bdat_q[0] <= '0;
      for (int i = 1; i < NST; i++) begin
        byp_q[i]  <= byp_q[i-1] | hit[i-1];
        bdat_q[i] <= hit[i-1] ? wr_data : bdat_q[i-1];
      end
    end
  end

  always_comb begin
    cap_data = ram_q;
    if (hit[RD_LATENCY])        cap_data = wr_data;
    else if (byp_q[RD_LATENCY]) cap_data = bdat_q[RD_LATENCY];
  end
`else
  assign cap_data = ram_q;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      scan_valid <= 1'b0;
      scan_addr  <= '0;
      scan_data  <= '0;
    end else begin
      scan_valid <= vld_q[RD_LATENCY];
      if (vld_q[RD_LATENCY]) begin
        scan_addr <= addr_q[RD_LATENCY];
        scan_data <= cap_data;
      end
    end
  end

endmodule

// File: rtl/ram_access_sched.sv
// Owns both ports of the ram32x4: host/clear write arbitration plus read scanner.
// Optional macro RAM_ACCESS_SCHED_RAW_BYPASS_EN forwards writes into in-flight scan reads.
module ram_access_sched
  import ram_sched_pkg::*;
#(
  parameter int            AW         = DEF_AW,
  parameter int            DW         = DEF_DW,
  parameter logic [DW-1:0] CLEAR_VAL  = DW'(DEF_CLEAR_VAL),
  parameter int            RD_LATENCY = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          scan_en,
  input  logic          clr_start,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_ack,
  output logic          busy,
  output logic [AW-1:0] scan_addr,
  output logic [DW-1:0] scan_data,
  output logic          scan_valid,
  output logic [AW-1:0] ram_wraddress,
  output logic [DW-1:0] ram_data,
  output logic          ram_wren,
  output logic [AW-1:0] ram_rdaddress,
  input  logic [DW-1:0] ram_q
);

  localparam int DEPTH = 2**AW;

  sched_state_t  state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          hw_pend_q, hw_pend_d;
  logic [AW-1:0] hw_addr_q, hw_addr_d;
  logic [DW-1:0] hw_data_q, hw_data_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      idx_q     <= '0;
      hw_pend_q <= 1'b0;
      hw_addr_q <= '0;
      hw_data_q <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      hw_pend_q <= hw_pend_d;
      hw_addr_q <= hw_addr_d;
      hw_data_q <= hw_data_d;
    end
  end

  // A host write is only granted from IDLE without a competing clear; the
  // granted write appears on the RAM port the following cycle.
  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    hw_pend_d = 1'b0;
    hw_addr_d = hw_addr_q;
    hw_data_d = hw_data_q;
    unique case (state_q)
      IDLE: begin
        if (clr_start) begin
          state_d = CLEAR;
          idx_d   = '0;
        end else if (wr_req) begin
          hw_pend_d = 1'b1;
          hw_addr_d = wr_addr;
          hw_data_d = wr_data;
        end
      end
      CLEAR: begin
        idx_d = idx_q + 1'b1;
        if (idx_q == AW'(DEPTH-1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy          = (state_q == CLEAR);
  assign wr_ack        = hw_pend_q;
  assign ram_wren      = busy | hw_pend_q;
  assign ram_wraddress = busy ? idx_q : hw_addr_q;
  assign ram_data      = busy ? CLEAR_VAL : hw_data_q;

  scan_seq #(
    .AW         (AW),
    .DW         (DW),
    .RD_LATENCY (RD_LATENCY)
  ) u_scan (
    .clk           (clk),
    .reset         (reset),
    .tick          (tick),
    .scan_en       (scan_en),
`ifdef RAM_ACCESS_SCHED_RAW_BYPASS_EN
    .wr_en         (ram_wren),
    .wr_addr       (ram_wraddress),
    .wr_data       (ram_data),
`endif
    .ram_q         (ram_q),
    .ram_rdaddress (ram_rdaddress),
    .scan_addr     (scan_addr),
    .scan_data     (scan_data),
    .scan_valid    (scan_valid)
  );

endmodule

// File: doc/ram_access_sched.md
Name: ram_access_sched

Overview:
- Scheduler/arbiter that owns both ports of the 32x4 dual-port RAM (ram32x4) on the DE1_SoC board.
- Write port: shared between an external host writer (switch/key front end) and an internal clear engine that fills memory with a constant.
- Read port: driven by a tick-paced address scanner that replaces the divided-clock counter. RAM reads become single-clock-domain and are delivered as address/data/valid to the hex display path.

Parameters:
- AW, 5, address width; memory depth DEPTH = 2**AW is a derived localparam, not overridable.
- DW, 4, data width.
- CLEAR_VAL, 4'h0, value written by the clear engine.
- RD_LATENCY, 1, clock edges from ram_rdaddress being presented to ram_q being valid; legal values 1..2.

Ports:
- clk  input  1  system clock (CLOCK_50 at top level).
- reset  input  1  asynchronous, active-low reset; asserting low clears all state immediately.
- tick  input  1  single-cycle scan step enable (from clock-divider pulse logic).
- scan_en  input  1  1 = scanner advances on tick; 0 = scan pointer frozen.
- clr_start  input  1  single-cycle request to clear the whole memory.
- wr_req  input  1  host write request.
- wr_addr  input  AW  host write address.
- wr_data  input  DW  host write data.
- wr_ack  output  1  one-cycle pulse per accepted host write.
- busy  output  1  high while the clear engine owns the write port.
- scan_addr  output  AW  address of the last delivered read.
- scan_data  output  DW  data of the last delivered read.
- scan_valid  output  1  one-cycle pulse when scan_addr/scan_data update.
- ram_wraddress  output  AW  to RAM.
- ram_data  output  DW  to RAM.
- ram_wren  output  1  to RAM, active-high.
- ram_rdaddress  output  AW  to RAM.
- ram_q  input  DW  from RAM.

Behaviour:
- Reset values:
  - State is IDLE and the scan pointer is 0.
  - Every output is 0; ram_rdaddress is 0.
- Write-port FSM states: IDLE, CLEAR.
- IDLE, host write accepted:
  - Condition: wr_req=1 and clr_start=0 at a clock edge.
  - On the next cycle, ram_wren=1, ram_wraddress=wr_addr and ram_data=wr_data (values as sampled); wr_ack=1 in the same cycle.
  - Back-to-back writes are allowed, one per cycle. A requester that holds wr_req high after wr_ack gets another write.
- IDLE, clr_start=1:
  - Go to CLEAR with the clear index set to 0.
  - clr_start wins over a simultaneous wr_req; that write is not acked and stays pending.
- CLEAR:
  - Each cycle: ram_wren=1, ram_wraddress=index, ram_data=CLEAR_VAL; index increments.
  - busy=1 for the DEPTH cycles that carry clear writes.
  - After the write to address DEPTH-1, return to IDLE; busy drops in the same cycle.
  - wr_req is held off (no ack) and clr_start is ignored while in CLEAR.
  - First host write can be acked on the cycle after busy falls.
- Outside a granted write or clear cycle, ram_wren is 0.
- Scanner:
  - On an edge with tick=1 and scan_en=1, the pointer increments modulo DEPTH (DEPTH-1 wraps to 0). ram_rdaddress takes the new pointer value at that edge (registered).
  - scan_valid pulses exactly RD_LATENCY+1 edges after the tick edge. scan_addr is that pointer value and scan_data is the captured ram_q.
  - Reads are pipelined, so ticks on consecutive cycles each produce a scan_valid.
  - tick while scan_en=0 is ignored.
  - The scanner runs independently of the FSM, including during CLEAR.
- Read/write collision: without the optional feature, the RAM read-during-write result (old data) is passed through unchanged.
- Reset asserted mid-clear: the clear is abandoned and partially written contents remain; no auto-restart on release.

Optional Feature:
- Macro: RAM_ACCESS_SCHED_RAW_BYPASS_EN.
- Defined: a write issued to the address of an in-flight scan read, on any cycle from ram_rdaddress presentation through capture, overrides the captured scan_data with the latest such write data.
- Undefined: scan_data always equals ram_q; no compare logic is built.

Decomposition:
- Package ram_sched_pkg holds:
  - the state enum typedef (IDLE, CLEAR);
  - default AW/DW constants;
  - the CLEAR_VAL default.
- Sub-module scan_seq holds the pointer, latency valid shift register and capture/bypass logic. The top holds the FSM and write mux.

Test Plan:
- Reset low mid-run, then high -> all outputs 0, ram_rdaddress=0; the first tick yields scan_addr=1 with scan_valid RD_LATENCY+1 edges later.
- wr_req with addr=5'd1/data=4'h5, then addr=5'd2/data=4'h3 on consecutive cycles -> two wr_ack pulses, ram_wren high for 2 cycles; scanning to addresses 1 and 2 returns 5 and 3.
- clr_start and wr_req(addr=3, data=9) in the same cycle -> busy high 32 cycles, ram_wraddress 0..31 with data 0; write acked on the cycle after busy falls; scan at address 3 reads 9.
- Scan with tick every cycle from pointer 30 -> scan_addr sequence 31, 0, 1 with scan_valid high on consecutive cycles.
- scan_en=0 with ticks for 10 cycles -> no scan_valid, ram_rdaddress unchanged.
- Macro defined: write addr=7/data=4'hC in the cycle ram_rdaddress=7 is presented -> scan_data=4'hC; macro undefined -> scan_data equals the old RAM value.
